radix4_booth_mul: RTL and testbench

//  Parametrised iterative radix-4 Booth multiplier for the EXU MUL path; generalises the fixed 64-bit unit.

---
 rtl/mul_pkg.sv | 25 ++
 rtl/booth_r4_pp.sv | 42 ++++
 rtl/radix4_booth_mul.sv | 177 +++++++++++++++++
 tb/tb_radix4_booth_mul.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_pkg
//  Purpose  : Shared FSM states, signedness encodings and DPC legality check
//             for the radix-4 Booth multiplier.
//  Revision : 1.0  initial release
// ============================================================================
package mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MUL_SS = 2'b11;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_UU = 2'b00;

  function automatic bit dpc_legal(input int dpc);
    return (dpc == 1) || (dpc == 2) || (dpc == 4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_pp.sv
`default_nettype none
// ============================================================================
//  Module   : booth_r4_pp
//  Purpose  : One radix-4 Booth digit: selects 0/+-x/+-2x; negation is
//             returned as one's complement plus a separate carry-in (neg).
//  Revision : 1.0  initial release
// ============================================================================
module booth_r4_pp
  import mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]          digit,
  input  logic [2*XLEN+3:0]   x,
  output logic [2*XLEN+3:0]   pp,
  output logic                neg
);

  logic [2*XLEN+3:0] w_mag;

  always_comb begin
    w_mag = '0;
    neg   = 1'b0;
    case (digit)
      3'b001, 3'b010: w_mag = x;
      3'b011:         w_mag = x << 1;
      3'b100: begin
        w_mag = x << 1;
        neg   = 1'b1;
      end
      3'b101, 3'b110: begin
        w_mag = x;
        neg   = 1'b1;
      end
      default: w_mag = '0;
    endcase
  end

  assign pp = neg ? ~w_mag : w_mag;

endmodule
`default_nettype wire

// File: rtl/radix4_booth_mul.sv
`default_nettype none
// ============================================================================
//  Module   : radix4_booth_mul
//  Purpose  : Iterative radix-4 Booth multiplier, DPC digits per cycle,
//             full/half width, three signedness modes, output backpressure.
//             Optional macro MUL_EARLY_TERM_EN: data-dependent early finish.
//  Revision : 1.0  initial release
// ============================================================================
module radix4_booth_mul
  import mul_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int DPC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic            mul_half,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int c_xw      = 2*XLEN + 4;
  localparam int c_yw      = XLEN + 3;
  localparam int c_hw      = XLEN / 2;
  localparam int c_nd_full = (XLEN + 2) / 2;
  localparam int c_nd_half = (c_hw + 2) / 2;
  localparam int c_cw      = $clog2(c_nd_full + 1);

  generate
    if (!dpc_legal(DPC)) begin : g_dpc_illegal
      $error("radix4_booth_mul: DPC must be 1, 2 or 4");
    end
    if ((XLEN % 2 != 0) || (XLEN < 8)) begin : g_xlen_illegal
      $error("radix4_booth_mul: XLEN must be even and >= 8");
    end
  endgenerate

  state_t            r_state;
  state_t            w_state_next;
  logic [c_xw-1:0]   r_acc;
  logic [c_xw-1:0]   r_x;
  logic [c_yw-1:0]   r_y;
  logic [c_cw-1:0]   r_cnt;
  logic [XLEN-1:0]   r_res_hi;
  logic [XLEN-1:0]   r_res_lo;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_finish;
  logic              w_early;
  logic [c_cw-1:0]   w_cnt_next;
  logic [c_cw-1:0]   w_nd;
  logic [c_xw-1:0]   w_x_load;
  logic [c_yw-1:0]   w_y_load;
  logic [c_xw-1:0]   w_x_shift;
  logic [c_yw-1:0]   w_y_shift;
  logic [c_xw-1:0]   w_sum;
  logic [c_xw-1:0]   w_acc_final;
  logic              w_unused_acc_top;

  // Operand extension: multiplicand signed for ss/su, multiplier only for ss.
  logic w_cand_ext;
  logic w_ier_ext;

  assign w_cand_ext = ((mul_signed == MUL_SS) || (mul_signed == MUL_SU)) &
                      (mul_half ? multiplicand[c_hw-1] : multiplicand[XLEN-1]);
  assign w_ier_ext  = (mul_signed == MUL_SS) &
                      (mul_half ? multiplier[c_hw-1] : multiplier[XLEN-1]);

  assign w_x_load = mul_half ? {{(c_xw-c_hw){w_cand_ext}}, multiplicand[c_hw-1:0]}
                             : {{(c_xw-XLEN){w_cand_ext}}, multiplicand};
  assign w_y_load = mul_half ? {{(XLEN+2-c_hw){w_ier_ext}}, multiplier[c_hw-1:0], 1'b0}
                             : {{2{w_ier_ext}}, multiplier, 1'b0};
  assign w_nd     = mul_half ? c_cw'(c_nd_half) : c_cw'(c_nd_full);

  assign w_x_shift  = r_x << (2*DPC);
  assign w_y_shift  = c_yw'($signed(r_y) >>> (2*DPC));
  assign w_cnt_next = (r_cnt <= c_cw'(DPC)) ? '0 : (r_cnt - c_cw'(DPC));

  logic [c_xw-1:0] w_xs  [DPC];
  logic [c_xw-1:0] w_pp  [DPC];
  logic [DPC-1:0]  w_neg;

  generate
    for (genvar gi = 0; gi < DPC; gi++) begin : g_pp
      assign w_xs[gi] = r_x << (2*gi);
      booth_r4_pp #(.XLEN(XLEN)) u_pp (
        .digit (r_y[2*gi+2:2*gi]),
        .x     (w_xs[gi]),
        .pp    (w_pp[gi]),
        .neg   (w_neg[gi])
      );
    end
  endgenerate

  always_comb begin
    w_sum = r_acc;
    for (int i = 0; i < DPC; i++) begin
      w_sum = w_sum + w_pp[i] + c_xw'(w_neg[i]);
    end
  end

`ifdef MUL_EARLY_TERM_EN
  // Remaining digits can only contribute zero once y is all-0/all-1 or x is 0.
  assign w_early = (r_y == '0) || (&r_y) || (r_x == '0);
`else
  assign w_early = 1'b0;
`endif

  assign w_acc_final      = w_early ? r_acc : w_sum;
  assign w_unused_acc_top = ^w_acc_final[c_xw-1:2*XLEN];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (mul_valid) w_state_next = S_BUSY;
      S_BUSY:  if (w_early || (w_cnt_next == '0)) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  assign w_accept = (r_state == S_IDLE) && mul_valid && !flush;
  assign w_finish = (r_state == S_BUSY) && (w_state_next == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_cnt       <= '0;
      r_res_hi    <= '0;
      r_res_lo    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x   <= w_x_load;
        r_y   <= w_y_load;
        r_acc <= '0;
        r_cnt <= w_nd;
      end else if (r_state == S_BUSY) begin
        r_acc <= w_acc_final;
        r_x   <= w_x_shift;
        r_y   <= w_y_shift;
        r_cnt <= w_cnt_next;
      end
      if (w_finish) begin
        r_res_hi    <= w_acc_final[2*XLEN-1:XLEN];
        r_res_lo    <= w_acc_final[XLEN-1:0];
        r_out_valid <= 1'b1;
      end else if (flush || ((r_state == S_DONE) && out_ready)) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign mul_ready = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result_hi = r_res_hi;
  assign result_lo = r_res_lo;

endmodule
`default_nettype wire

// File: tb/tb_radix4_booth_mul.sv
`default_nettype none
// ============================================================================
//  Module   : tb_radix4_booth_mul
//  Purpose  : Scoreboard bench: driver pushes reference products, a negedge
//             monitor compares whenever out_valid is presented.
//  Revision : 1.0  initial release
// ============================================================================
module tb_radix4_booth_mul;

  localparam int XLEN = 64;
  localparam int DPC  = 1;
  localparam int RW   = 2*XLEN;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            mul_valid = 1'b0;
  logic            mul_ready;
  logic            mul_half = 1'b0;
  logic [1:0]      mul_signed = 2'b00;
  logic [XLEN-1:0] multiplicand = '0;
  logic [XLEN-1:0] multiplier = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result_hi;
  logic [XLEN-1:0] result_lo;

  radix4_booth_mul #(.XLEN(XLEN), .DPC(DPC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .mul_valid    (mul_valid),
    .mul_ready    (mul_ready),
    .mul_half     (mul_half),
    .mul_signed   (mul_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_hi    (result_hi),
    .result_lo    (result_lo)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: extend each W-bit operand per signedness, multiply as integers.
  function automatic logic [RW-1:0] ref_mul(input bit half, input logic [1:0] sgn,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [RW+1:0] sa, sb, p;
    bit cs, ys;
    cs = (sgn == 2'b11) || (sgn == 2'b10);
    ys = (sgn == 2'b11);
    if (half) begin
      sa = {{(XLEN+2+XLEN/2){cs & a[XLEN/2-1]}}, a[XLEN/2-1:0]};
      sb = {{(XLEN+2+XLEN/2){ys & b[XLEN/2-1]}}, b[XLEN/2-1:0]};
    end else begin
      sa = {{(XLEN+2){cs & a[XLEN-1]}}, a};
      sb = {{(XLEN+2){ys & b[XLEN-1]}}, b};
    end
    p = sa * sb;
    return p[RW-1:0];
  endfunction

  function automatic int exp_lat(input bit half);
    int nd;
    nd = half ? (XLEN/2 + 2)/2 : (XLEN + 2)/2;
    return (nd + DPC - 1) / DPC;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out_valid: got result %h with no op outstanding", {result_hi, result_lo});
      end else begin
        check("result", {result_hi, result_lo}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input bit half, input logic [1:0] sgn, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [RW-1:0] exp, input int hold);
    int  n;
    bit  done;
    @(posedge clk); #1;
    mul_valid = 1'b1; mul_half = half; mul_signed = sgn;
    multiplicand = a; multiplier = b;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    mul_valid = 1'b0;
    n = 0; done = 1'b0;
    while (!done && n < 300) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (out_valid) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL timeout: got no out_valid in %0d cycles required %0d", n, exp_lat(half));
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
`ifdef MUL_EARLY_TERM_EN
    n_checks++;
    if (n <= exp_lat(half)) n_pass++;
    else $display("FAIL latency: got %0d required <= %0d", n, exp_lat(half));
`else
    check("latency", RW'(n), RW'(exp_lat(half)));
`endif
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("done_hold", RW'({out_valid, mul_ready}), RW'(2'b10));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_ack", RW'({out_valid, mul_ready}), RW'(2'b01));
  endtask

  function automatic logic [XLEN-1:0] rand_operand();
    logic [XLEN-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(XLEN-1){1'b0}}};
      3:       v = {{(XLEN/2){1'b0}}, 1'b1, {(XLEN/2-1){1'b0}}};
      4:       v = XLEN'($urandom_range(0, 15));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XLEN-1:0] a, b;
    logic [1:0]      s;
    bit              h;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {result_hi, result_lo}, '0);
    check("reset_flags", RW'({out_valid, mul_ready}), RW'(2'b01));
    rst_n = 1'b1;

    run_op(1'b0, 2'b00, '1, '1, {{(XLEN-1){1'b1}}, 1'b0, {(XLEN-1){1'b0}}, 1'b1}, 0);
    run_op(1'b0, 2'b11, '1, '1, {{(XLEN){1'b0}}, {(XLEN-1){1'b0}}, 1'b1}, 0);
    run_op(1'b0, 2'b10, '1, '1, {{(XLEN){1'b1}}, {(XLEN-1){1'b0}}, 1'b1}, 0);
    run_op(1'b1, 2'b11, 64'hDEAD_BEEF_8000_0000, 64'h1234_5678_8000_0000,
           {64'h0, 64'h4000_0000_0000_0000}, 0);
    run_op(1'b1, 2'b00, 64'hA5A5_A5A5_FFFF_FFFF, 64'h5A5A_5A5A_FFFF_FFFF,
           {64'h0, 64'hFFFF_FFFE_0000_0001}, 0);
    run_op(1'b1, 2'b11, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0002,
           {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE}, 0);
    run_op(1'b0, 2'b01, 64'h8000_0000_0000_0000, 64'h2,
           {64'h1, 64'h0}, 10);
    run_op(1'b0, 2'b00, 64'h7, 64'h0, '0, 0);

    // Flush in the fifth BUSY cycle: op must vanish without a result.
    @(posedge clk); #1;
    mul_valid = 1'b1; mul_half = 1'b0; mul_signed = 2'b11;
    multiplicand = 64'h0123_4567_89AB_CDEF; multiplier = 64'hDEAD_BEEF_CAFE_BABE;
    @(posedge clk); #1;
    mul_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", RW'({out_valid, mul_ready}), RW'(2'b01));
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("flush_busy_quiet", RW'({out_valid, mul_ready}), RW'(2'b01));

    // Flush beats a simultaneous request in IDLE.
    @(posedge clk); #1;
    mul_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    mul_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle", RW'({out_valid, mul_ready}), RW'(2'b01));
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("flush_idle_quiet", RW'({out_valid, mul_ready}), RW'(2'b01));

    // Async reset mid-BUSY clears everything, including the held result.
    @(posedge clk); #1;
    mul_valid = 1'b1; mul_signed = 2'b00;
    multiplicand = 64'h0FED_CBA9_8765_4321; multiplier = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    mul_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midbusy_reset_result", {result_hi, result_lo}, '0);
    check("midbusy_reset_flags", RW'({out_valid, mul_ready}), RW'(2'b01));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("post_reset_quiet", RW'({out_valid, mul_ready}), RW'(2'b01));

    for (int i = 0; i < 400; i++) begin
      h = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = rand_operand();
      b = rand_operand();
      run_op(h, s, a, b, ref_mul(h, s, a, b), int'($urandom_range(0, 2)));
    end

    repeat (5) @(posedge clk);
    check("queue_drained", RW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
